// File: rtl/ob_rsp_tx.sv
// ob_rsp_tx -- order-book response transmitter.
//
// Accepts one response (uid/status/result) over a valid/accept handshake and
// serializes it MSB first into a 16-byte frame on a byte-wide egress link:
//   byte 0      : 8'hA0 | status
//   bytes 1..4  : uid[31:0], MSB byte first
//   bytes 5..14 : result[79:0], MSB byte first
//   byte 15     : XOR of bytes 0..14
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rsp_vld, rsp    response in; rsp is the ob_pkg::rsp_t bit layout:
//                   uid[114:83], status[82:80], result[79:0]
//   rsp_accept      response taken when rsp_vld & rsp_accept (decoded from state)
//   out_vld/out_data/out_last  registered byte stream, out_last on byte 15
//   out_accept      sink takes byte when out_vld & out_accept
//   frame_cnt       completed frames, wraps modulo 2^FRAME_CNT_W
module ob_rsp_tx #(
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsp_vld,
  input  logic [114:0]           rsp,
  output logic                   rsp_accept,
  output logic                   out_vld,
  output logic [7:0]             out_data,
  output logic                   out_last,
  input  logic                   out_accept,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t state, state_nxt;

  logic [114:0] hold;
  logic [3:0]   idx;
  logic [7:0]   csum;

  logic         cap;
  logic         adv;
  logic         fin;

  logic [119:0] body;
  logic [3:0]   idx_nxt;
  logic [7:0]   byte_sel;
  logic [7:0]   byte_nxt;
  logic [7:0]   byte0_in;

  // Bytes 0..14 of the frame as one vector; byte k sits at [8*(14-k) +: 8].
  assign body     = {5'b10100, hold[82:80], hold[114:83], hold[79:0]};
  assign byte0_in = {5'b10100, rsp[82:80]};
  assign idx_nxt  = idx + 4'd1;

  always_comb begin
    byte_sel = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (idx_nxt == 4'(i)) byte_sel = body[8*(14-i) +: 8];
    end
  end

  // The byte after 14 is the checksum: running XOR of 0..13 plus the byte
  // currently on out_data (byte 14).
  assign byte_nxt = (idx_nxt == 4'd15) ? (csum ^ out_data) : byte_sel;

  always_comb begin
    state_nxt  = state;
    cap        = 1'b0;
    adv        = 1'b0;
    fin        = 1'b0;
    rsp_accept = 1'b0;
    case (state)
      S_IDLE: begin
        rsp_accept = ~rst;
        if (rsp_vld) begin
          cap       = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (out_accept) begin
          if (idx == 4'd15) begin
            fin       = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      idx       <= '0;
      csum      <= '0;
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else if (cap) begin
      hold     <= rsp;
      idx      <= '0;
      csum     <= '0;
      out_vld  <= 1'b1;
      out_data <= byte0_in;
      out_last <= 1'b0;
    end else if (adv) begin
      idx      <= idx_nxt;
      csum     <= csum ^ out_data;
      out_data <= byte_nxt;
      out_last <= (idx_nxt == 4'd15);
    end else if (fin) begin
      idx       <= '0;
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule
